port_bus_master: RTL and testbench
==================================

PORT_BUS_MASTER -- requirements
Module: port_bus_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command offered.
REQ-005 cmd_ready  output  1  FIFO can accept a command (not full).
REQ-006 cmd_write  input  1  1 = port write, 0 = port read.
REQ-007 cmd_port  input  8  target port address.
REQ-008 cmd_data  input  8  write data; ignored for reads.
REQ-009 port_id  output  8  port address driven to peripherals.
REQ-010 out_port  output  8  write data driven to peripherals.
REQ-011 write_strobe  output  1  one-cycle write qualifier.
REQ-012 read_strobe  output  1  one-cycle read qualifier.
REQ-013 in_port  input  8  combinational read data from the peripheral decode, valid while port_id is stable.
REQ-014 rsp_valid  output  1  read response held.
REQ-015 rsp_ready  input  1  host consumes the response.
REQ-016 rsp_data  output  8  captured read data.
REQ-017 rsp_port  output  8  port address of the captured read.
REQ-018 busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-019 The block SHALL issue port cycles compatible with the processor port bus: the same peripheral decode (write_strobe-qualified registers, combinational in_port mux on port_id) works unchanged.
REQ-020 A command SHALL be pushed when cmd_valid && cmd_ready on a rising edge; cmd_ready = FIFO not full, with no combinational path from cmd_valid.
REQ-021 FSM states SHALL be IDLE, SETUP, STROBE.
REQ-022 IDLE: if FIFO non-empty, pop the head, load port_id (and out_port for writes), go to SETUP; otherwise stay.
REQ-023 SETUP: both strobes low; go to STROBE, except a read stalls in SETUP while rsp_valid=1.
REQ-024 STROBE: exactly one cycle with write_strobe=1 (write) or read_strobe=1 (read), never both; a read captures in_port into rsp_data, and port_id into rsp_port, at the end of this cycle and sets rsp_valid.
REQ-025 From STROBE: if the FIFO is non-empty, pop and go directly to SETUP; else go to IDLE. Back-to-back throughput SHALL be one command per 2 cycles.
REQ-026 Latency SHALL be fixed: command accepted on edge T gives SETUP in cycle T+1, STROBE in T+2, rsp_valid=1 from T+3 for reads.
REQ-027 port_id SHALL stay constant across SETUP and STROBE, and hold its last value in IDLE.
REQ-028 out_port SHALL change only when a write command is popped; reads leave it unchanged.
REQ-029 rsp_valid SHALL clear on the edge where rsp_valid && rsp_ready, and a capture on that same edge sets it again with the new data.
REQ-030 Full FIFO: cmd_ready=0, and a pop frees a slot for the next cycle only.
REQ-031 A push into an empty FIFO SHALL NOT bypass it; the pop occurs the following cycle.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 While reset=1, the block SHALL force: FSM to IDLE; FIFO empty; port_id=0x00; out_port=0x00; write_strobe=0; read_strobe=0; rsp_valid=0; rsp_data=0x00; rsp_port=0x00; busy=0.
REQ-034 The block SHALL set cmd_ready=1 while reset=1.
REQ-035 Reset asserted mid-transaction SHALL drop the strobes immediately, without waiting for a clock edge, and discard all queued commands and any pending response.
REQ-036 The first command SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Single write (write, port 0x02, data 0xA5) at edge T -> cycle T+1: port_id=0x02, out_port=0xA5, strobes 0; cycle T+2: write_strobe=1; cycle T+3: IDLE, busy=0.
REQ-038 Single read (read, port 0x01), in_port model returns 0x3C for port 0x01 -> read_strobe=1 in T+2; rsp_valid=1, rsp_data=0x3C, rsp_port=0x01 from T+3.
REQ-039 Push 5 writes back-to-back with FIFO_DEPTH=4 and the FSM drained slowly -> cmd_ready falls when 4 entries are held; write_strobe pulses every 2nd cycle, in order, ports 0x10..0x14.
REQ-040 Two reads (0x00 then 0x01) with rsp_ready=0 -> first response held; second read stalls in SETUP with read_strobe=0; raise rsp_ready for one cycle -> second STROBE follows and rsp_data updates.
REQ-041 Assert reset during a STROBE cycle with 3 commands queued -> strobes 0 immediately; after release FIFO empty, rsp_valid=0, port_id=0x00, and no further strobes.
REQ-042 Alternate read/write to ports 0x02/0x03 against the standard LED/switch decode -> LED registers and read-back match a scoreboard with zero mismatches over 1000 random commands.

Source files
------------

// File: rtl/port_bus_master.sv
// -----------------------------------------------------------------------------
// port_bus_master
//
// Turns a stream of queued host commands into processor-style port bus cycles.
// Each command takes two cycles on the bus: a SETUP cycle with port_id (and
// out_port for writes) stable and both strobes low, then a STROBE cycle with
// exactly one of write_strobe / read_strobe high. Reads capture in_port at
// the end of STROBE into a single-entry response register. A read is held in
// SETUP until that register is empty, so a response is never overwritten.
// An existing write_strobe-qualified register decode and a combinational
// in_port mux on port_id can sit on this bus unchanged.
//
// Parameters
//   FIFO_DEPTH   command FIFO entries (power of two, 2..16)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   cmd_valid    host offers a command
//   cmd_ready    FIFO not full (registered, no path from cmd_valid)
//   cmd_write    1 = port write, 0 = port read
//   cmd_port     target port address
//   cmd_data     write data (ignored for reads)
//   port_id      port address driven to peripherals
//   out_port     write data driven to peripherals
//   write_strobe one-cycle write qualifier
//   read_strobe  one-cycle read qualifier
//   in_port      combinational read data from the peripheral decode
//   rsp_valid    read response held
//   rsp_ready    host consumes the response
//   rsp_data     captured read data
//   rsp_port     port address of the captured read
//   busy         FIFO non-empty or a bus cycle in progress
// -----------------------------------------------------------------------------
module port_bus_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_port,
  input  logic [7:0] cmd_data,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_port,
  output logic       busy
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic       write;
    logic [7:0] port;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  cmd_t             head;
  logic             push;
  logic             pop;

  state_e     state_q;
  logic       cur_write_q;
  logic [7:0] port_id_q;
  logic [7:0] out_port_q;
  logic       write_strobe_q;
  logic       read_strobe_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic [7:0] rsp_port_q;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  // The FSM only takes a new command from IDLE or while leaving STROBE, so a
  // push into an empty FIFO is always seen one cycle later, never bypassed.
  assign pop       = (count_q != '0) && ((state_q == IDLE) || (state_q == STROBE));

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness is defined by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{write: cmd_write, port: cmd_port, data: cmd_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Bus cycle FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_write_q    <= 1'b0;
      port_id_q      <= '0;
      out_port_q     <= '0;
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_port_q     <= '0;
    end else begin
      // NOTE: strobes default low each cycle so they can only ever be one-cycle pulses.
      write_strobe_q <= 1'b0;
      read_strobe_q  <= 1'b0;

      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pop) state_q <= SETUP;
        end
        SETUP: begin
          // Reads wait here until the response register is free.
          if (cur_write_q || !rsp_valid_q) begin
            state_q        <= STROBE;
            write_strobe_q <= cur_write_q;
            read_strobe_q  <= !cur_write_q;
          end
        end
        STROBE: begin
          // Capture wins over a same-edge consume, so the new data is kept.
          if (!cur_write_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= in_port;
            rsp_port_q  <= port_id_q;
          end
          state_q <= pop ? SETUP : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // port_id holds otherwise; out_port only moves for writes.
      if (pop) begin
        cur_write_q <= head.write;
        port_id_q   <= head.port;
        if (head.write) out_port_q <= head.data;
      end
    end
  end

  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = write_strobe_q;
  assign read_strobe  = read_strobe_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_port     = rsp_port_q;
  assign busy         = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_port_bus_master.sv
// -----------------------------------------------------------------------------
// tb_port_bus_master
//
// Drives port_bus_master against a small peripheral model: an LED register at
// port 0x02 (written on write_strobe, readable back), switches at port 0x03,
// fixed values at ports 0x00/0x01, and ~port_id elsewhere. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_port_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_port;
  logic [7:0] cmd_data;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_port;
  logic       busy;

  port_bus_master #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_port     (cmd_port),
    .cmd_data     (cmd_data),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_port     (rsp_port),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Peripheral model: LED register and combinational input mux.
  logic [7:0] led_q;
  logic [7:0] sw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_q <= '0;
    else if (write_strobe && port_id == 8'h02) led_q <= out_port;
  end

  always_comb begin
    case (port_id)
      8'h00:   in_port = 8'h5A;
      8'h01:   in_port = 8'h3C;
      8'h02:   in_port = led_q;
      8'h03:   in_port = sw;
      default: in_port = ~port_id;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one command and return on the falling edge after it is taken.
  task automatic push(input logic w, input logic [7:0] p, input logic [7:0] d);
    cmd_write = w;
    cmd_port  = p;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) cyc();
    check("push_accept", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] exp_out;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs [8];

  // Sequence bookkeeping
  int         n_rs;
  int         idx;
  int         full_cnt;
  bit         full_seen;
  bit         going;
  bit         r0_seen;
  logic [7:0] r0_data;
  logic [7:0] w_port [$];
  logic [7:0] w_out  [$];
  int         w_cyc  [$];
  int         n_strb;
  bit         busy_seen;

  // Random phase
  logic [15:0] sb [$];
  logic [15:0] exp_rsp;
  logic [7:0]  led_m;
  int          sent;
  bit          done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{wr: 1'b1, port: 8'h02, data: 8'hA5, exp_out: 8'hA5, exp_rsp: 8'h00};
    vecs[1] = '{wr: 1'b0, port: 8'h01, data: 8'h00, exp_out: 8'hA5, exp_rsp: 8'h3C};
    vecs[2] = '{wr: 1'b0, port: 8'h02, data: 8'hEE, exp_out: 8'hA5, exp_rsp: 8'hA5};
    vecs[3] = '{wr: 1'b1, port: 8'h07, data: 8'h11, exp_out: 8'h11, exp_rsp: 8'h00};
    vecs[4] = '{wr: 1'b0, port: 8'h03, data: 8'h00, exp_out: 8'h11, exp_rsp: 8'h96};
    vecs[5] = '{wr: 1'b0, port: 8'h40, data: 8'h00, exp_out: 8'h11, exp_rsp: 8'hBF};
    vecs[6] = '{wr: 1'b1, port: 8'hFF, data: 8'h00, exp_out: 8'h00, exp_rsp: 8'h00};
    vecs[7] = '{wr: 1'b0, port: 8'h02, data: 8'h00, exp_out: 8'h00, exp_rsp: 8'hA5};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_port  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    sw        = 8'h96;
    cyc();
    cyc();

    // ---- Reset state ----
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy",      busy, 0);
    check("rst_port_id",   port_id, 8'h00);
    check("rst_out_port",  out_port, 8'h00);
    check("rst_strobes",   {write_strobe, read_strobe}, 2'b00);
    check("rst_rsp",       {rsp_valid, rsp_data, rsp_port}, 17'h0);

    reset = 1'b0;

    // ---- Single-command table: fixed latency and response capture ----
    for (int i = 0; i < 8; i++) begin
      cmd_write = vecs[i].wr;
      cmd_port  = vecs[i].port;
      cmd_data  = vecs[i].data;
      cmd_valid = 1'b1;
      check($sformatf("v%0d_ready", i), cmd_ready, 1);
      cyc();                                   // edge T: accepted
      cmd_valid = 1'b0;
      check($sformatf("v%0d_busy_T", i), busy, 1);
      check($sformatf("v%0d_strb_T", i), {write_strobe, read_strobe}, 2'b00);
      cyc();                                   // SETUP
      check($sformatf("v%0d_setup_port", i), port_id, vecs[i].port);
      check($sformatf("v%0d_setup_out", i),  out_port, vecs[i].exp_out);
      check($sformatf("v%0d_setup_strb", i), {write_strobe, read_strobe}, 2'b00);
      cyc();                                   // STROBE
      check($sformatf("v%0d_strobe", i), {write_strobe, read_strobe}, {vecs[i].wr, !vecs[i].wr});
      check($sformatf("v%0d_strobe_port", i), port_id, vecs[i].port);
      cyc();                                   // back to IDLE
      check($sformatf("v%0d_idle_busy", i), busy, 0);
      check($sformatf("v%0d_idle_strb", i), {write_strobe, read_strobe}, 2'b00);
      check($sformatf("v%0d_idle_port", i), port_id, vecs[i].port);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, !vecs[i].wr);
      if (!vecs[i].wr) begin
        check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_rsp);
        check($sformatf("v%0d_rsp_port", i), rsp_port, vecs[i].port);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_clear", i), rsp_valid, 0);
      end
    end

    // ---- Two reads with rsp_ready low: second stalls in SETUP ----
    push(1'b0, 8'h00, 8'h00);
    push(1'b0, 8'h01, 8'h00);
    n_rs = 0;
    for (int i = 0; i < 8; i++) begin
      if (read_strobe) n_rs++;
      cyc();
    end
    check("stall_one_strobe", n_rs, 1);
    check("stall_rsp_valid",  rsp_valid, 1);
    check("stall_rsp_data",   rsp_data, 8'h5A);
    check("stall_rsp_port",   rsp_port, 8'h00);
    check("stall_port_id",    port_id, 8'h01);
    check("stall_no_strobe",  read_strobe, 0);
    check("stall_busy",       busy, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("release_rsp_clear", rsp_valid, 0);
    check("release_setup",     read_strobe, 0);
    cyc();
    check("release_strobe",    read_strobe, 1);
    check("release_strobe_id", port_id, 8'h01);
    cyc();
    check("release_rsp_valid", rsp_valid, 1);
    check("release_rsp_data",  rsp_data, 8'h3C);
    check("release_rsp_port",  rsp_port, 8'h01);

    // ---- Fill the FIFO behind a stalled read, then drain ----
    push(1'b0, 8'h00, 8'h00);                  // stalls: response still held
    idx       = 0;
    full_cnt  = 0;
    full_seen = 1'b0;
    r0_seen   = 1'b0;
    r0_data   = '0;
    cmd_write = 1'b1;
    cmd_port  = 8'h10;
    cmd_data  = 8'hC0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (write_strobe) begin
        w_port.push_back(port_id);
        w_out.push_back(out_port);
        w_cyc.push_back(c);
      end
      if (rsp_valid && rsp_port == 8'h00 && !r0_seen) begin
        r0_seen = 1'b1;
        r0_data = rsp_data;
      end
      if (cmd_valid && !cmd_ready) begin
        if (!full_seen) check("full_at_four", idx, 4);
        full_seen = 1'b1;
        full_cnt++;
        if (full_cnt == 3) rsp_ready = 1'b1;
      end
      going = cmd_valid && cmd_ready;
      cyc();
      if (going) begin
        idx++;
        if (idx < 5) begin
          cmd_port = 8'h10 + 8'(idx);
          cmd_data = 8'hC0 + 8'(idx);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    check("full_seen",      full_seen, 1);
    check("all_pushed",     idx, 5);
    check("wstrobe_count",  w_port.size(), 5);
    for (int i = 0; i < 5 && i < w_port.size(); i++) begin
      check($sformatf("wstrobe%0d_port", i), w_port[i], 8'h10 + 8'(i));
      check($sformatf("wstrobe%0d_data", i), w_out[i], 8'hC0 + 8'(i));
      if (i > 0) check($sformatf("wstrobe%0d_gap", i), w_cyc[i] - w_cyc[i-1], 2);
    end
    check("stalled_read_seen", r0_seen, 1);
    check("stalled_read_data", r0_data, 8'h5A);
    check("drain_idle",        busy, 0);

    // ---- Reset during a STROBE with three commands queued ----
    rsp_ready = 1'b0;
    push(1'b0, 8'h01, 8'h00);
    push(1'b0, 8'h05, 8'h00);
    push(1'b1, 8'h21, 8'h01);
    push(1'b1, 8'h22, 8'h02);
    push(1'b1, 8'h23, 8'h03);
    cyc();
    check("pre_rst_stalled", {busy, rsp_valid, port_id}, {1'b1, 1'b1, 8'h05});
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !read_strobe; i++) cyc();
    check("pre_rst_strobe", read_strobe, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_strobes",   {write_strobe, read_strobe}, 2'b00);
    check("mid_rst_busy",      busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_port_id",   port_id, 8'h00);
    check("mid_rst_out_port",  out_port, 8'h00);
    cyc();
    cyc();
    reset     = 1'b0;
    n_strb    = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (write_strobe || read_strobe) n_strb++;
      if (busy) busy_seen = 1'b1;
      cyc();
    end
    check("post_rst_no_strobes", n_strb, 0);
    check("post_rst_fifo_empty", busy_seen, 0);
    check("post_rst_rsp_valid",  rsp_valid, 0);
    check("post_rst_port_id",    port_id, 8'h00);

    // ---- Random alternating LED writes / LED-switch reads ----
    sw    = 8'($urandom);
    led_m = 8'h00;
    sent  = 0;
    done  = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (sent == 1000 && sb.size() == 0 && !busy && !rsp_valid) begin
        done = 1'b1;
        break;
      end
      rsp_ready = ($urandom_range(3) != 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rand_unexpected_rsp", {rsp_port, rsp_data}, 16'h0000);
        end else begin
          exp_rsp = sb.pop_front();
          check("rand_rsp", {rsp_port, rsp_data}, exp_rsp);
        end
      end
      going = cmd_valid && cmd_ready;
      cyc();
      if (going) begin
        sent++;
        if (cmd_write) led_m = cmd_data;
        else sb.push_back({cmd_port, (cmd_port == 8'h02) ? led_m : sw});
        cmd_valid = 1'b0;
      end
      if (!cmd_valid && sent < 1000 && $urandom_range(3) != 0) begin
        cmd_write = (sent % 2 == 0);
        cmd_port  = cmd_write ? 8'h02 : (($urandom_range(1) == 0) ? 8'h02 : 8'h03);
        cmd_data  = 8'($urandom);
        cmd_valid = 1'b1;
      end
    end
    rsp_ready = 1'b0;
    check("rand_complete", done, 1);
    check("rand_led",      led_q, led_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
